// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_B1   = 2'd1,
      IF_RESP = 2'd2,
      DM_RESP = 2'd3
   } state_t;

   // Word offset of the second (lower) instruction half within a fetch burst.
   localparam int unsigned BEAT_OFFSET = 1;

   // Default number of consecutive data grants tolerated while a fetch waits.
   localparam int unsigned STARVE_MAX_DEF = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, synchronous-read 16-bit memory between
// instruction fetch (atomic two-beat burst, 32-bit result) and the data
// memory stage (single 16-bit read/write). Data has priority; a starvation
// counter forces a fetch grant after STARVE_MAX data grants with a fetch
// pending.
//
// Handshake: a requester raises req with stable attributes and holds it until
// its ready pulse. Ready is a single-cycle pulse. The requester's own req is
// ignored in its ready cycle, so it may drop req or keep it high to request
// the next access, which is arbitrated from the following cycle.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic              if_ready,
   output logic [31:0]       if_data,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [15:0]       dm_wdata,
   output logic              dm_ready,
   output logic [15:0]       dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   output state_t            dbg_state
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   state_t           state_q, state_d;
   logic [15:0]      hi_q;
   logic [CNT_W-1:0] starve_cnt;
   logic             starve_sat;
   logic             if_elig, dm_elig, fetch_win;
   logic             if_grant, dm_grant;

   assign dbg_state  = state_q;
   assign starve_sat = (starve_cnt == CNT_W'(STARVE_MAX));

   // Eligibility: each requester is masked in its own ready cycle; a killed
   // fetch never competes, which lets data win that cycle instead.
   assign if_elig   = if_req && !if_kill && (state_q != IF_RESP);
   assign dm_elig   = dm_req && (state_q != DM_RESP);
   assign fetch_win = if_elig && (!dm_elig || starve_sat);

   // Ready pulses decode from state and if_kill only; response data is
   // forced to zero outside its response cycle.
   assign if_ready = (state_q == IF_RESP) && !if_kill;
   assign dm_ready = (state_q == DM_RESP);
   assign if_data  = (state_q == IF_RESP) ? {hi_q, mem_rdata} : 32'h0;
   assign dm_rdata = (state_q == DM_RESP) ? mem_rdata : 16'h0;

   // Next-state and memory-port decode; nothing is issued while reset is held.
   always_comb begin
      state_d   = state_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_grant  = 1'b0;
      dm_grant  = 1'b0;
      if (rst) begin
         case (state_q)
            IDLE, IF_RESP, DM_RESP: begin
               if (fetch_win) begin
                  mem_en   = 1'b1;
                  mem_addr = if_addr;
                  if_grant = 1'b1;
                  state_d  = IF_B1;
               end else if (dm_elig) begin
                  mem_en    = 1'b1;
                  mem_we    = dm_wr;
                  mem_addr  = dm_addr;
                  mem_wdata = dm_wdata;
                  dm_grant  = 1'b1;
                  state_d   = DM_RESP;
               end else begin
                  state_d = IDLE;
               end
            end
            IF_B1: begin
               // Second beat is never preempted by data; only a kill aborts it.
               if (!if_kill) begin
                  mem_en   = 1'b1;
                  mem_addr = if_addr + ADDR_W'(BEAT_OFFSET);
                  state_d  = IF_RESP;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Capture beat 0 (upper instruction half) as it returns in IF_B1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  hi_q <= 16'h0;
      else if (state_q == IF_B1) hi_q <= mem_rdata;
   end

   // Saturating count of data grants made while a live fetch is waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   starve_cnt <= '0;
      else if (!if_req || if_grant)               starve_cnt <= '0;
      else if (dm_grant && !if_kill && !starve_sat) starve_cnt <= starve_cnt + CNT_W'(1);
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random
// sequence, with per-port expected queues checked on each ready pulse.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, if_ready;
   logic [15:0] if_addr;
   logic [31:0] if_data;
   logic        dm_req, dm_wr, dm_ready;
   logic [15:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   state_t      dbg_state;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];

   logic [31:0] exp_if_q[$];
   logic [16:0] exp_dm_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_ready(if_ready), .if_data(if_data),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // single-port synchronous-read memory model
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: pop and compare on every ready pulse
   logic [31:0] e_if;
   logic [16:0] e_dm;
   always @(negedge clk) begin
      if (rst === 1'b1 && if_ready === 1'b1) begin
         if (exp_if_q.size() == 0) check("if_ready_unexpected", 32'(if_ready), 32'd0);
         else begin
            e_if = exp_if_q.pop_front();
            check("if_data", if_data, e_if);
         end
      end
      if (rst === 1'b1 && dm_ready === 1'b1) begin
         if (exp_dm_q.size() == 0) check("dm_ready_unexpected", 32'(dm_ready), 32'd0);
         else begin
            e_dm = exp_dm_q.pop_front();
            if (e_dm[16]) check("dm_rdata", 32'(dm_rdata), 32'(e_dm[15:0]));
         end
      end
   end

   // driver: directed fetch with beat address checks
   task automatic do_fetch(input logic [15:0] a, input logic [31:0] exp, input string tag);
      logic [15:0] a1;
      a1 = a + 16'd1;
      if_req = 1'b1; if_addr = a;
      exp_if_q.push_back(exp);
      @(negedge clk);
      check({tag, "_b0_addr"}, 32'(mem_addr), 32'(a));
      check({tag, "_b0_en"}, 32'(mem_en & ~mem_we), 32'd1);
      cyc();
      @(negedge clk);
      check({tag, "_b1_addr"}, 32'(mem_addr), 32'(a1));
      check({tag, "_b1_en"}, 32'(mem_en), 32'd1);
      cyc();
      @(negedge clk);
      check({tag, "_ready"}, 32'(if_ready), 32'd1);
      cyc();
      if_req = 1'b0;
   endtask

   // driver: directed single data access
   task automatic do_data(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp, input string tag);
      dm_req = 1'b1; dm_wr = wr; dm_addr = a; dm_wdata = wd;
      exp_dm_q.push_back({~wr, exp});
      @(negedge clk);
      check({tag, "_addr"}, 32'(mem_addr), 32'(a));
      check({tag, "_en_we"}, 32'({mem_en, mem_we}), 32'({1'b1, wr}));
      cyc();
      @(negedge clk);
      check({tag, "_ready"}, 32'(dm_ready), 32'd1);
      cyc();
      dm_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'(i) ^ 16'h5A5A;
         ref_mem[i] = 16'(i) ^ 16'h5A5A;
      end
      mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
      mem[16'h0020] = 16'h1234; ref_mem[16'h0020] = 16'h1234;
      mem[16'h0021] = 16'h5678; ref_mem[16'h0021] = 16'h5678;
      mem[16'h0040] = 16'hCAFE; ref_mem[16'h0040] = 16'hCAFE;
      mem[16'h0041] = 16'hF00D; ref_mem[16'h0041] = 16'hF00D;
      mem[16'hFFFF] = 16'h9ABC; ref_mem[16'hFFFF] = 16'h9ABC;
      mem[16'h0000] = 16'hDEF0; ref_mem[16'h0000] = 16'hDEF0;

      // reset with requests asserted: every output must stay 0
      rst = 1'b0; if_kill = 1'b0;
      if_req = 1'b1; if_addr = 16'h1111;
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h2222; dm_wdata = 16'hFFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_dm_ready", 32'(dm_ready), 32'd0);
      check("rst_if_data", if_data, 32'd0);
      check("rst_dm_rdata", 32'(dm_rdata), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      cyc();
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      rst = 1'b1;
      cyc();

      // single read
      do_data(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "rd");

      // single fetch
      do_fetch(16'h0020, 32'h12345678, "fetch");

      // collision: data write first, fetch granted in the DM_RESP cycle
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'hAAAA;
      if_req = 1'b1; if_addr = 16'h0040;
      exp_dm_q.push_back({1'b0, 16'h0000});
      exp_if_q.push_back(32'hCAFEF00D);
      ref_mem[16'h0030] = 16'hAAAA;
      @(negedge clk);
      check("col_dm_grant", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b1, 16'h0030}));
      check("col_wdata", 32'(mem_wdata), 32'h0000AAAA);
      cyc();
      @(negedge clk);
      check("col_dm_ready", 32'(dm_ready), 32'd1);
      check("col_if_grant", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'h0040}));
      cyc();
      dm_req = 1'b0;
      @(negedge clk);
      check("col_b1_addr", 32'(mem_addr), 32'h00000041);
      cyc();
      @(negedge clk);
      check("col_if_ready", 32'(if_ready), 32'd1);
      cyc();
      if_req = 1'b0;
      check("col_mem30", 32'(mem[16'h0030]), 32'h0000AAAA);
      do_data(1'b0, 16'h0030, 16'h0000, 16'hAAAA, "col_rdback");

      // starvation: four data grants with a fetch pending, then the fetch wins
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0050;
      if_req = 1'b1; if_addr = 16'h0060;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("starve_dm%0d", k), 32'({mem_en, mem_addr}), 32'({1'b1, 16'h0050}));
         exp_dm_q.push_back({1'b1, ref_mem[16'h0050]});
         cyc();
         // hold the fetch off in the data response cycle so data keeps winning
         if_kill = 1'b1;
         @(negedge clk);
         check($sformatf("starve_gap%0d", k), 32'(mem_en), 32'd0);
         cyc();
         if_kill = 1'b0;
      end
      exp_if_q.push_back({ref_mem[16'h0060], ref_mem[16'h0061]});
      @(negedge clk);
      check("starve_if_grant", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h0060}));
      cyc();
      @(negedge clk);
      check("starve_atomic", 32'(mem_addr), 32'h00000061);
      cyc();
      @(negedge clk);
      check("starve_if_ready", 32'(if_ready), 32'd1);
      check("starve_dm_resume", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h0050}));
      exp_dm_q.push_back({1'b1, ref_mem[16'h0050]});
      cyc();
      if_req = 1'b0;
      @(negedge clk);
      check("starve_resp_idle", 32'(mem_en), 32'd0);
      cyc();
      @(negedge clk);
      check("starve_dm_again", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h0050}));
      exp_dm_q.push_back({1'b1, ref_mem[16'h0050]});
      cyc();
      dm_req = 1'b0;
      cyc();

      // kill in IF_B1: no beat 1, no ready, back to IDLE
      if_req = 1'b1; if_addr = 16'h0070;
      cyc();
      if_kill = 1'b1;
      @(negedge clk);
      check("kill_b1_en", 32'(mem_en), 32'd0);
      check("kill_b1_ready", 32'(if_ready), 32'd0);
      cyc();
      if_kill = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check("kill_b1_state", 32'(dbg_state), 32'(IDLE));
      check("kill_b1_noready", 32'(if_ready), 32'd0);
      cyc();

      // kill in IF_RESP: ready suppressed
      if_req = 1'b1; if_addr = 16'h0070;
      cyc();
      cyc();
      if_kill = 1'b1;
      @(negedge clk);
      check("kill_resp_ready", 32'(if_ready), 32'd0);
      cyc();
      if_kill = 1'b0; if_req = 1'b0;
      cyc();

      // reset during IF_B1 abandons the burst
      if_req = 1'b1; if_addr = 16'h0080;
      cyc();
      rst = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check("rstb_mem_en", 32'(mem_en), 32'd0);
      check("rstb_mem_addr", 32'(mem_addr), 32'd0);
      check("rstb_state", 32'(dbg_state), 32'(IDLE));
      check("rstb_if_ready", 32'(if_ready), 32'd0);
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rstb_after%0d", k), 32'({if_ready, mem_en}), 32'd0);
         cyc();
      end

      // address wrap on beat 1
      do_fetch(16'hFFFF, 32'h9ABCDEF0, "wrap");

      // random mix: data in 0x100..0x10F, fetches in 0x200..0x20F
      for (int it = 0; it < 30; it++) begin
         int unsigned op;
         logic dm_done, if_done, timed_out;
         logic [15:0] a, a1;
         op = $urandom_range(0, 2);
         dm_done = 1'b1; if_done = 1'b1;
         if (op != 1) begin
            dm_wr    = 1'($urandom_range(0, 1));
            dm_addr  = 16'h0100 + 16'($urandom_range(0, 15));
            dm_wdata = 16'($urandom);
            if (dm_wr) begin
               ref_mem[dm_addr] = dm_wdata;
               exp_dm_q.push_back({1'b0, 16'h0000});
            end else begin
               exp_dm_q.push_back({1'b1, ref_mem[dm_addr]});
            end
            dm_req = 1'b1; dm_done = 1'b0;
         end
         if (op != 0) begin
            a  = 16'h0200 + 16'($urandom_range(0, 15));
            a1 = a + 16'd1;
            if_addr = a;
            exp_if_q.push_back({ref_mem[a], ref_mem[a1]});
            if_req = 1'b1; if_done = 1'b0;
         end
         timed_out = 1'b1;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dm_ready) dm_done = 1'b1;
            if (if_ready) if_done = 1'b1;
            cyc();
            if (dm_done) dm_req = 1'b0;
            if (if_done) if_req = 1'b0;
            if (dm_done && if_done) begin
               timed_out = 1'b0;
               break;
            end
         end
         if (timed_out) check($sformatf("rand_timeout%0d", it), 32'({dm_done, if_done}), 32'd3);
         dm_req = 1'b0; if_req = 1'b0;
         repeat ($urandom_range(0, 2)) cyc();
      end

      cyc();
      cyc();
      check("if_q_drained", 32'(exp_if_q.size()), 32'd0);
      check("dm_q_drained", 32'(exp_dm_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_mem_arbiter
